// File: rtl/jjt_bias_engine.sv
// Computes J*J^T + bias*I over the upper triangle with L multiplier lanes, double-buffered result.
// Latency B+MULT_LAT+1 cycles from accepted start (B = N(N+1)/2 * ceil(M/L)); en=0 freezes all state.
module jjt_bias_engine #(
   parameter int N        = 6,
   parameter int M        = 6,
   parameter int L        = 6,
   parameter int W        = 27,
   parameter int FRAC     = 14,
   parameter int MULT_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               start,
   input  logic [N*M*W-1:0]   jacobian_matrix,
   input  logic [W-1:0]       bias,
   output logic               busy,
   output logic               done,
   output logic [7:0]         count,
   output logic [N*N*W-1:0]   jjt_bias
);

   localparam int K  = (M + L - 1) / L;
   localparam int AW = 2*W + $clog2(M);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int DW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state;
   logic [N*M*W-1:0]      jm_q;
   logic signed [W-1:0]   bias_q;
   logic [IW-1:0]         ent_i, ent_j;
   logic [KW-1:0]         beat_k;
   logic [DW-1:0]         drain_cnt;

   logic signed [W-1:0]   op_a [L];
   logic signed [W-1:0]   op_b [L];

   logic signed [2*W-1:0] prod  [MULT_LAT][L];
   logic [MULT_LAT-1:0]   p_vld, p_first, p_last;
   logic [IW-1:0]         p_i [MULT_LAT];
   logic [IW-1:0]         p_j [MULT_LAT];

   logic signed [AW-1:0]  acc, lane_sum, acc_next, shifted;
   logic signed [AW:0]    bias_ext, biased;
   logic                  fits;
   logic signed [W-1:0]   sat_val, entry_val;
   logic signed [W-1:0]   shadow [N][N];

   // Lane l of beat k carries column k*L+l of rows i and j; columns past M-1 contribute zero.
   always_comb begin
      for (int l = 0; l < L; l++) begin
         op_a[l] = '0;
         op_b[l] = '0;
         if (int'(beat_k)*L + l < M) begin
            op_a[l] = jm_q[(int'(ent_i)*M + int'(beat_k)*L + l)*W +: W];
            op_b[l] = jm_q[(int'(ent_j)*M + int'(beat_k)*L + l)*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_vld   <= '0;
         p_first <= '0;
         p_last  <= '0;
         for (int s = 0; s < MULT_LAT; s++) begin
            p_i[s] <= '0;
            p_j[s] <= '0;
            for (int l = 0; l < L; l++) prod[s][l] <= '0;
         end
      end else if (en) begin
         p_vld[0]   <= (state == RUN);
         p_first[0] <= (beat_k == '0);
         p_last[0]  <= (beat_k == KW'(K-1));
         p_i[0]     <= ent_i;
         p_j[0]     <= ent_j;
         for (int l = 0; l < L; l++)
            prod[0][l] <= (2*W)'(op_a[l]) * (2*W)'(op_b[l]);
         for (int s = 1; s < MULT_LAT; s++) begin
            p_vld[s]   <= p_vld[s-1];
            p_first[s] <= p_first[s-1];
            p_last[s]  <= p_last[s-1];
            p_i[s]     <= p_i[s-1];
            p_j[s]     <= p_j[s-1];
            for (int l = 0; l < L; l++) prod[s][l] <= prod[s-1][l];
         end
      end
   end

   // Full-precision accumulate, then a single floor shift, diagonal bias and saturation per entry.
   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < L; l++)
         lane_sum = lane_sum + AW'(prod[MULT_LAT-1][l]);
      acc_next  = p_first[MULT_LAT-1] ? lane_sum : acc + lane_sum;
      shifted   = acc_next >>> FRAC;
      bias_ext  = (p_i[MULT_LAT-1] == p_j[MULT_LAT-1]) ? (AW+1)'(bias_q) : '0;
      biased    = (AW+1)'(shifted) + bias_ext;
      fits      = (biased[AW:W-1] == {(AW-W+2){biased[W-1]}});
      sat_val   = biased[AW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      entry_val = fits ? biased[W-1:0] : sat_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) shadow[i][j] <= '0;
      end else if (en) begin
         if (state == IDLE && start) begin
            acc <= '0;
         end else if (p_vld[MULT_LAT-1]) begin
            acc <= acc_next;
            if (p_last[MULT_LAT-1]) begin
               shadow[p_i[MULT_LAT-1]][p_j[MULT_LAT-1]] <= entry_val;
               shadow[p_j[MULT_LAT-1]][p_i[MULT_LAT-1]] <= entry_val;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         count     <= '0;
         ent_i     <= '0;
         ent_j     <= '0;
         beat_k    <= '0;
         drain_cnt <= '0;
         jm_q      <= '0;
         bias_q    <= '0;
         jjt_bias  <= '0;
      end else if (en) begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               jm_q   <= jacobian_matrix;
               bias_q <= bias;
               count  <= '0;
               ent_i  <= '0;
               ent_j  <= '0;
               beat_k <= '0;
               busy   <= 1'b1;
               state  <= RUN;
            end
            RUN: begin
               if (count != 8'hFF) count <= count + 8'd1;
               if (beat_k == KW'(K-1)) begin
                  beat_k <= '0;
                  if (ent_j == IW'(N-1)) begin
                     if (ent_i == IW'(N-1)) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                     end else begin
                        ent_i <= ent_i + IW'(1);
                        ent_j <= ent_i + IW'(1);
                     end
                  end else begin
                     ent_j <= ent_j + IW'(1);
                  end
               end else begin
                  beat_k <= beat_k + KW'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt == DW'(MULT_LAT-1)) state <= DONE;
               else drain_cnt <= drain_cnt + DW'(1);
            end
            DONE: begin
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++)
                     jjt_bias[(i*N+j)*W +: W] <= shadow[i][j];
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jjt_bias_engine.sv
// Bench for jjt_bias_engine: default 6x6 instance plus a partial-lane N=2, M=7, L=3 instance.
module tb_jjt_bias_engine;
   localparam int N = 6, M = 6, W = 27, FRAC = 14;
   localparam int PN = 2, PM = 7, PL = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1, start = 1'b0;
   logic [N*M*W-1:0] jm = '0;
   logic [W-1:0]     bias = '0;
   logic             busy, done;
   logic [7:0]       count;
   logic [N*N*W-1:0] jjt;

   logic p_en = 1'b1, p_start = 1'b0;
   logic [PN*PM*W-1:0] p_jm = '0;
   logic [W-1:0]       p_bias = '0;
   logic               p_busy, p_done;
   logic [7:0]         p_count;
   logic [PN*PN*W-1:0] p_jjt;

   int n_checks = 0;
   int n_fail = 0;
   logic [N*N*W-1:0]   exp_q[$];
   logic [PN*PN*W-1:0] p_exp_q[$];

   always #5 clk = ~clk;

   jjt_bias_engine dut (
      .clk(clk), .rst(rst), .en(en), .start(start),
      .jacobian_matrix(jm), .bias(bias),
      .busy(busy), .done(done), .count(count), .jjt_bias(jjt)
   );

   jjt_bias_engine #(.N(PN), .M(PM), .L(PL), .W(W), .FRAC(FRAC), .MULT_LAT(2)) dut_p (
      .clk(clk), .rst(rst), .en(p_en), .start(p_start),
      .jacobian_matrix(p_jm), .bias(p_bias),
      .busy(p_busy), .done(p_done), .count(p_count), .jjt_bias(p_jjt)
   );

   // kind 0: diagonal val, kind 1: all val, kind 2: rows 0-2 = +val, rows 3-5 = -val
   function automatic logic [N*M*W-1:0] fill(input int kind, input int val);
      logic [N*M*W-1:0] res;
      int x;
      res = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < M; c++) begin
            case (kind)
               0:       x = (r == c) ? val : 0;
               1:       x = val;
               default: x = (r < 3) ? val : -val;
            endcase
            res[(r*M+c)*W +: W] = W'(x);
         end
      return res;
   endfunction

   function automatic logic [N*N*W-1:0] model(input logic [N*M*W-1:0] m, input logic [W-1:0] b);
      logic [N*N*W-1:0] res;
      logic signed [W-1:0] x, y, bs;
      longint acc, v, lim;
      res = '0;
      bs  = b;
      lim = longint'(1) <<< (W-1);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int c = 0; c < M; c++) begin
               x = m[(i*M+c)*W +: W];
               y = m[(j*M+c)*W +: W];
               acc += longint'(x) * longint'(y);
            end
            v = acc >>> FRAC;
            if (i == j) v += longint'(bs);
            if (v > lim - 1) v = lim - 1;
            if (v < -lim) v = -lim;
            res[(i*N+j)*W +: W] = v[W-1:0];
         end
      return res;
   endfunction

   // Accepts a start at the next edge; buses are scrambled afterwards.
   task automatic start_run(input logic [N*M*W-1:0] m, input logic [W-1:0] b, input bit push);
      @(negedge clk);
      jm = m;
      bias = b;
      start = 1'b1;
      if (push) exp_q.push_back(model(m, b));
      @(posedge clk);
      #1;
      start = 1'b0;
      jm = ~m;
      bias = ~b;
   endtask

   task automatic wait_done(input int budget, input logic [63:0] stall_mask,
                            input logic [63:0] start_mask, output int lat, output int busy_cyc);
      lat = -1;
      busy_cyc = busy ? 1 : 0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         en = ~stall_mask[cyc];
         start = start_mask[cyc];
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            lat = cyc;
            break;
         end
         if (busy) busy_cyc++;
      end
      en = 1'b1;
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
      n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      n_checks++; if (jjt !== '0) begin n_fail++; $display("FAIL reset_jjt got nonzero exp all zero"); end
      n_checks++; if (p_busy !== 1'b0 || p_count !== 8'd0 || p_jjt !== '0) begin
         n_fail++; $display("FAIL reset_partial busy=%b count=%0d exp 0/0 and zero matrix", p_busy, p_count);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_identity;
      int lat, bc;
      logic [N*N*W-1:0] e;
      start_run(fill(0, 16384), W'(164), 1);
      wait_done(60, '0, '0, lat, bc);
      e = exp_q.pop_front();
      n_checks++; if (lat != 24) begin n_fail++; $display("FAIL ident_latency got %0d exp 24", lat); end
      n_checks++; if (bc != 24) begin n_fail++; $display("FAIL ident_busy_cycles got %0d exp 24", bc); end
      n_checks++; if (count !== 8'd21) begin n_fail++; $display("FAIL ident_count got %0d exp 21", count); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ident_busy_at_done got %b exp 0", busy); end
      for (int k = 0; k < N*N; k++) begin
         n_checks++;
         if (jjt[k*W +: W] !== e[k*W +: W]) begin
            n_fail++;
            $display("FAIL ident_elem[%0d][%0d] got %0d exp %0d", k/N, k%N, $signed(jjt[k*W +: W]), $signed(e[k*W +: W]));
         end
      end
      @(posedge clk);
      #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ident_done_pulse_width got %b exp 0", done); end
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      logic [N*N*W-1:0] e;
      for (int r = 0; r < 2; r++) begin
         start_run(fill(1, 16384), (r == 0) ? W'(0) : W'(164), 1);
         wait_done(60, '0, '0, lat, bc);
         e = exp_q.pop_front();
         n_checks++; if (lat != 24) begin n_fail++; $display("FAIL b2b_latency run%0d got %0d exp 24", r, lat); end
         for (int k = 0; k < N*N; k++) begin
            n_checks++;
            if (jjt[k*W +: W] !== e[k*W +: W]) begin
               n_fail++;
               $display("FAIL ones_elem run%0d [%0d][%0d] got %0d exp %0d", r, k/N, k%N, $signed(jjt[k*W +: W]), $signed(e[k*W +: W]));
            end
         end
      end
   endtask

   task automatic test_saturation;
      int lat, bc;
      logic [N*N*W-1:0] e;
      start_run(fill(2, 491520), W'(0), 1);
      wait_done(60, '0, '0, lat, bc);
      e = exp_q.pop_front();
      n_checks++; if (lat != 24) begin n_fail++; $display("FAIL sat_latency got %0d exp 24", lat); end
      for (int k = 0; k < N*N; k++) begin
         n_checks++;
         if (jjt[k*W +: W] !== e[k*W +: W]) begin
            n_fail++;
            $display("FAIL sat_elem[%0d][%0d] got %0d exp %0d", k/N, k%N, $signed(jjt[k*W +: W]), $signed(e[k*W +: W]));
         end
      end
   endtask

   task automatic test_partial_lanes;
      int lat;
      logic [PN*PN*W-1:0] e;
      logic [PN*PN*W-1:0] ev;
      @(negedge clk);
      for (int c = 0; c < PM; c++) begin
         p_jm[c*W +: W]      = W'((c + 1) * 16384);
         p_jm[(PM+c)*W +: W] = W'(16384);
      end
      p_bias = '0;
      ev = '0;
      ev[0*W +: W] = W'(140 * 16384);
      ev[1*W +: W] = W'(28 * 16384);
      ev[2*W +: W] = W'(28 * 16384);
      ev[3*W +: W] = W'(7 * 16384);
      p_exp_q.push_back(ev);
      p_start = 1'b1;
      @(posedge clk);
      #1;
      p_start = 1'b0;
      p_jm = '1;
      lat = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (p_done) begin lat = cyc; break; end
      end
      e = p_exp_q.pop_front();
      n_checks++; if (lat != 12) begin n_fail++; $display("FAIL partial_latency got %0d exp 12", lat); end
      n_checks++; if (p_count !== 8'd9) begin n_fail++; $display("FAIL partial_count got %0d exp 9", p_count); end
      for (int k = 0; k < PN*PN; k++) begin
         n_checks++;
         if (p_jjt[k*W +: W] !== e[k*W +: W]) begin
            n_fail++;
            $display("FAIL partial_elem[%0d][%0d] got %0d exp %0d", k/PN, k%PN, $signed(p_jjt[k*W +: W]), $signed(e[k*W +: W]));
         end
      end
   endtask

   task automatic test_stall_start_ignore;
      int lat, bc, nset;
      logic [63:0] smask, stmask;
      logic [N*N*W-1:0] e;
      smask = '0;
      nset = 0;
      while (nset < 5) begin
         int p;
         p = $urandom_range(17, 2);
         if (!smask[p]) begin smask[p] = 1'b1; nset++; end
      end
      stmask = '0;
      stmask[3] = 1'b1; stmask[8] = 1'b1; stmask[15] = 1'b1; stmask[22] = 1'b1;
      start_run(fill(0, 16384), W'(164), 1);
      wait_done(60, smask, stmask, lat, bc);
      e = exp_q.pop_front();
      n_checks++; if (lat != 29) begin n_fail++; $display("FAIL stall_latency got %0d exp 29", lat); end
      n_checks++; if (count !== 8'd21) begin n_fail++; $display("FAIL stall_count got %0d exp 21", count); end
      for (int k = 0; k < N*N; k++) begin
         n_checks++;
         if (jjt[k*W +: W] !== e[k*W +: W]) begin
            n_fail++;
            $display("FAIL stall_elem[%0d][%0d] got %0d exp %0d", k/N, k%N, $signed(jjt[k*W +: W]), $signed(e[k*W +: W]));
         end
      end
   endtask

   task automatic test_reset_midrun;
      int lat, bc, pulses;
      logic [N*N*W-1:0] e;
      start_run(fill(1, 16384), W'(0), 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
      n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", count); end
      n_checks++; if (jjt !== '0) begin n_fail++; $display("FAIL midrst_jjt got nonzero exp all zero"); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", done); end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_spurious_done got %0d exp 0", pulses); end
      start_run(fill(0, 16384), W'(164), 1);
      wait_done(60, '0, '0, lat, bc);
      e = exp_q.pop_front();
      n_checks++; if (lat != 24) begin n_fail++; $display("FAIL postrst_latency got %0d exp 24", lat); end
      for (int k = 0; k < N*N; k++) begin
         n_checks++;
         if (jjt[k*W +: W] !== e[k*W +: W]) begin
            n_fail++;
            $display("FAIL postrst_elem[%0d][%0d] got %0d exp %0d", k/N, k%N, $signed(jjt[k*W +: W]), $signed(e[k*W +: W]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_back_to_back();
      test_saturation();
      test_partial_lanes();
      test_stall_start_ignore();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
